// File: rtl/remote_comm.sv
// UART command link: sends a 16-bit command as two 8N1 bytes (high first) and receives 8N1 response bytes.
// TX takes 20*BAUD_DIV cycles per command and ignores send_cmd while busy; resp_rdy pulses ~9.5 bit times after a start edge.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        RST_n,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND_HI, TX_SEND_LO} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t   r_tx_state, w_tx_state_nxt;
  logic [11:0] r_tx_baud, w_tx_baud_nxt;
  logic [3:0]  r_tx_bit, w_tx_bit_nxt;
  logic        r_tx, w_tx_nxt;
  logic [15:0] r_cmd, w_cmd_nxt;
  logic        r_cmd_sent, w_cmd_sent_nxt;
  logic [7:0]  w_tx_byte;

  rx_state_t   r_rx_state, w_rx_state_nxt;
  logic [11:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]  r_rx_bit, w_rx_bit_nxt;
  logic [7:0]  r_rx_shift, w_rx_shift_nxt;
  logic        r_rx_armed, w_rx_armed_nxt;
  logic [7:0]  r_resp, w_resp_nxt;
  logic        r_resp_rdy, w_resp_rdy_nxt;
  logic        r_rx_s1, r_rx_s2;

  always_ff @(posedge clk) begin
    if (!RST_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx       <= 1'b1;
      r_cmd      <= '0;
      r_cmd_sent <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_baud  <= w_tx_baud_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx       <= w_tx_nxt;
      r_cmd      <= w_cmd_nxt;
      r_cmd_sent <= w_cmd_sent_nxt;
    end
  end

  // Bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_baud_nxt  = r_tx_baud;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_nxt       = r_tx;
    w_cmd_nxt      = r_cmd;
    w_cmd_sent_nxt = r_cmd_sent;
    w_tx_byte      = (r_tx_state == TX_SEND_HI) ? r_cmd[15:8] : r_cmd[7:0];
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        if (send_cmd) begin
          w_cmd_nxt      = cmd;
          w_cmd_sent_nxt = 1'b0;
          w_tx_state_nxt = TX_SEND_HI;
          w_tx_baud_nxt  = '0;
          w_tx_bit_nxt   = '0;
          w_tx_nxt       = 1'b0;
        end
      end
      TX_SEND_HI, TX_SEND_LO: begin
        if (r_tx_baud == BAUD_LAST) begin
          w_tx_baud_nxt = '0;
          if (r_tx_bit == 4'd9) begin
            w_tx_bit_nxt = '0;
            if (r_tx_state == TX_SEND_HI) begin
              w_tx_state_nxt = TX_SEND_LO;
              w_tx_nxt       = 1'b0;
            end else begin
              w_tx_state_nxt = TX_IDLE;
              w_cmd_sent_nxt = 1'b1;
              w_tx_nxt       = 1'b1;
            end
          end else begin
            w_tx_bit_nxt = r_tx_bit + 4'd1;
            w_tx_nxt     = (r_tx_bit == 4'd8) ? 1'b1 : w_tx_byte[r_tx_bit[2:0]];
          end
        end else begin
          w_tx_baud_nxt = r_tx_baud + 12'd1;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_armed <= 1'b0;
      r_resp     <= '0;
      r_resp_rdy <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_armed <= w_rx_armed_nxt;
      r_resp     <= w_resp_nxt;
      r_resp_rdy <= w_resp_rdy_nxt;
    end
  end

  // r_rx_armed means the line has been seen high, so a low level is a genuine falling edge.
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_armed_nxt = r_rx_armed;
    w_resp_nxt     = r_resp;
    w_resp_rdy_nxt = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_armed && !r_rx_s2) begin
          w_rx_state_nxt = RX_START;
          w_rx_armed_nxt = 1'b0;
        end else if (r_rx_s2) begin
          w_rx_armed_nxt = 1'b1;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = '0;
          w_rx_bit_nxt = '0;
          if (r_rx_s2) begin
            w_rx_state_nxt = RX_IDLE;
            w_rx_armed_nxt = 1'b1;
          end else begin
            w_rx_state_nxt = RX_DATA;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 12'd1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BAUD_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_s2, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_state_nxt = RX_STOP;
            w_rx_bit_nxt   = '0;
          end else begin
            w_rx_bit_nxt = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 12'd1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BAUD_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_IDLE;
          w_rx_armed_nxt = r_rx_s2;
          if (r_rx_s2) begin
            w_resp_nxt     = r_rx_shift;
            w_resp_rdy_nxt = 1'b1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + 12'd1;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign TX       = r_tx;
  assign cmd_sent = r_cmd_sent;
  assign resp     = r_resp;
  assign resp_rdy = r_resp_rdy;

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm at BAUD_DIV=16: command framing, send_cmd lockout, RX framing and reset aborts.
module tb_remote_comm;

  logic        clk;
  logic        RST_n;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        TX;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;

  int n_err = 0;
  int n_chk = 0;
  logic cap_tx   [0:339];
  logic cap_sent [0:339];

  remote_comm #(.BAUD_DIV(16)) dut (
    .clk(clk), .RST_n(RST_n), .cmd(cmd), .send_cmd(send_cmd), .cmd_sent(cmd_sent),
    .TX(TX), .RX(RX), .resp(resp), .resp_rdy(resp_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Sample i is taken half a cycle after edge E0+i, where E0 accepts the command.
  task automatic tx_run(input logic [15:0] c, input int poke_at, input logic [15:0] c2, input int rst_at);
    @(negedge clk);
    cmd = c;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    for (int i = 0; i < 340; i++) begin
      cap_tx[i]   = TX;
      cap_sent[i] = cmd_sent;
      send_cmd = (i == poke_at);
      if (i == poke_at) cmd = c2;
      if (i == rst_at) RST_n = 1'b0;
      if (i == rst_at + 2) RST_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [0:19] exp, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      logic [15:0] g;
      for (int j = 0; j < 16; j++) g[j] = cap_tx[16*k + j];
      chk($sformatf("%s_bit%0d", tag, k), 32'(g), exp[k] ? 32'h0000ffff : 32'h0);
    end
  endtask

  task automatic chk_done(input string tag);
    logic [15:0] g;
    for (int j = 0; j < 16; j++) g[j] = cap_tx[320 + j];
    chk({tag, "_sent_clr"}, 32'(cap_sent[0]), 32'd0);
    chk({tag, "_sent_319"}, 32'(cap_sent[319]), 32'd0);
    chk({tag, "_sent_320"}, 32'(cap_sent[320]), 32'd1);
    chk({tag, "_sent_hold"}, 32'(cap_sent[339]), 32'd1);
    chk({tag, "_tx_idle"}, 32'(g), 32'h0000ffff);
  endtask

  // RX falls at loop index 0; stimulus only, the frame is hand-specified by b/stop_bit.
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input int abort_at,
                          input int ncyc, output int lat, output int pulses);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    lat = -1;
    pulses = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (resp_rdy) begin
        pulses++;
        if (lat < 0) lat = c;
      end
      if (c == abort_at) RST_n = 1'b0;
      if (c == abort_at + 2) RST_n = 1'b1;
      if (abort_at >= 0 && c >= abort_at) RX = 1'b1;
      else RX = (c < 160) ? fr[c/16] : 1'b1;
    end
  endtask

  initial begin
    int lat, pulses, any_low, any_sent;
    logic [0:19] exp_2bf0;
    logic [0:19] exp_0000;
    exp_2bf0 = 20'b0110101001_0000011111;
    exp_0000 = 20'b0000000001_0000000001;
    RST_n = 1'b0;
    send_cmd = 1'b1;
    cmd = 16'hFFFF;
    RX = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_sent", 32'(cmd_sent), 32'd0);
    chk("rst_resp", 32'(resp), 32'h00);
    chk("rst_rdy", 32'(resp_rdy), 32'd0);
    send_cmd = 1'b0;
    RST_n = 1'b1;
    repeat (4) @(negedge clk);

    tx_run(16'h2BF0, -1, 16'h0000, -1);
    chk_frame("c2bf0", exp_2bf0, 20);
    chk_done("c2bf0");

    tx_run(16'h2BF0, 49, 16'h4000, -1);
    chk_frame("poke", exp_2bf0, 20);
    chk_done("poke");

    tx_run(16'h2BF0, 100, 16'h4000, 99);
    chk_frame("rst", exp_2bf0, 6);
    any_low = 0;
    any_sent = 0;
    for (int i = 100; i < 340; i++) begin
      if (!cap_tx[i]) any_low = 1;
      if (cap_sent[i]) any_sent = 1;
    end
    chk("rst_tx_high", 32'(any_low), 32'd0);
    chk("rst_no_sent", 32'(any_sent), 32'd0);

    tx_run(16'h0000, -1, 16'h0000, -1);
    chk_frame("c0000", exp_0000, 20);
    chk_done("c0000");

    rx_frame(8'hA5, 1'b1, -1, 200, lat, pulses);
    chk("rx_a5_resp", 32'(resp), 32'hA5);
    chk("rx_a5_pulses", 32'(pulses), 32'd1);
    chk("rx_a5_lat", 32'(lat >= 150 && lat <= 160), 32'd1);

    rx_frame(8'h3C, 1'b0, -1, 200, lat, pulses);
    chk("rx_ferr_resp", 32'(resp), 32'hA5);
    chk("rx_ferr_pulses", 32'(pulses), 32'd0);

    rx_frame(8'h5A, 1'b1, -1, 200, lat, pulses);
    chk("rx_5a_resp", 32'(resp), 32'h5A);
    chk("rx_5a_pulses", 32'(pulses), 32'd1);

    pulses = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (resp_rdy) pulses++;
      RX = (c < 3) ? 1'b0 : 1'b1;
    end
    chk("rx_glitch_pulses", 32'(pulses), 32'd0);
    chk("rx_glitch_resp", 32'(resp), 32'h5A);

    rx_frame(8'h81, 1'b1, -1, 160, lat, pulses);
    chk("rx_b2b1_pulses", 32'(pulses), 32'd1);
    chk("rx_b2b1_resp", 32'(resp), 32'h81);
    rx_frame(8'h7E, 1'b1, -1, 200, lat, pulses);
    chk("rx_b2b2_pulses", 32'(pulses), 32'd1);
    chk("rx_b2b2_resp", 32'(resp), 32'h7E);
    chk("rx_b2b2_lat", 32'(lat >= 150 && lat <= 160), 32'd1);

    rx_frame(8'hA5, 1'b1, 80, 200, lat, pulses);
    chk("rx_rst_pulses", 32'(pulses), 32'd0);
    chk("rx_rst_resp", 32'(resp), 32'h00);
    chk("rx_rst_tx", 32'(TX), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/remote_comm.md
REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, giving clocks per UART bit (50 MHz / 19200 baud); legal range 8..4095.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST_n  input  1  reset; synchronous and active-low, sampled on rising clk.
REQ-004 SHALL have port cmd  input  16  command word to transmit; sampled only when a send is accepted.
REQ-005 SHALL have port send_cmd  input  1  request to transmit cmd.
REQ-006 SHALL have port cmd_sent  output  1  level; high once both bytes of the accepted command are fully on the line.
REQ-007 SHALL have port TX  output  1  serial out, 8N1, LSB first, idle high.
REQ-008 SHALL have port RX  input  1  serial in, 8N1, LSB first, asynchronous to clk.
REQ-009 SHALL have port resp  output  8  last correctly framed response byte.
REQ-010 SHALL have port resp_rdy  output  1  one-cycle pulse when resp is updated.

Function
REQ-011 Transmit FSM SHALL have states IDLE, SEND_HI, SEND_LO.
REQ-012 In IDLE, send_cmd sampled high at edge E0 SHALL: latch cmd, clear cmd_sent, go to SEND_HI, drive TX=0 (start bit) from E0.
REQ-013 Each byte frame SHALL be start(0), 8 data bits LSB first, stop(1); each bit held exactly BAUD_DIV clocks.
REQ-014 SEND_HI SHALL send cmd[15:8]; SEND_LO SHALL send cmd[7:0], starting with no idle gap after the high-byte stop bit.
REQ-015 At edge E0+20*BAUD_DIV the FSM SHALL return to IDLE, set cmd_sent=1, and hold TX=1.
REQ-016 cmd_sent SHALL stay high until the next accepted send_cmd.
REQ-017 send_cmd outside IDLE SHALL be ignored: no re-latch, no restart, no change in timing.
REQ-018 The baud counter SHALL be 12 bits and the bit counter SHALL count 0..9 per frame; neither SHALL wrap past its terminal value.
REQ-019 RX SHALL be synchronised by two flops, with TX/RX paths fully independent and able to run simultaneously.
REQ-020 Receiver states SHALL be IDLE, START, DATA, STOP; IDLE->START on a synchronised falling edge of RX.
REQ-021 In START the receiver SHALL sample after BAUD_DIV/2 clocks; if RX is high (glitch) it SHALL return to IDLE with no output.
REQ-022 Data bits and stop bit SHALL be sampled every BAUD_DIV clocks after the mid-start sample.
REQ-023 If the stop bit samples 1, the receiver SHALL load resp with the shifted byte and pulse resp_rdy for exactly one clock, in the same cycle as the resp update.
REQ-024 If the stop bit samples 0 (framing error), the receiver SHALL discard the byte, leave resp unchanged, emit no resp_rdy, and wait for RX high before re-arming.
REQ-025 A new falling edge during STOP evaluation SHALL NOT be lost; the receiver SHALL be re-armed in IDLE the cycle after the stop sample.

Reset
REQ-026 While RST_n=0 at a rising edge: both FSMs to IDLE, TX=1, cmd_sent=0, resp=8'h00, resp_rdy=0, all counters and shift registers 0, synchroniser flops 1.
REQ-027 Reset mid-frame SHALL abort the frame; TX=1 from the reset edge and no cmd_sent or resp_rdy SHALL be produced for the aborted transfer.
REQ-028 send_cmd SHALL be ignored while RST_n=0.

Verification
REQ-029 Reset: hold RST_n=0 for 2 clocks -> TX=1, cmd_sent=0, resp=00, resp_rdy=0.
REQ-030 BAUD_DIV=16, send cmd=16'h2BF0 -> TX bits 0,1,1,0,1,0,1,0,0,1 then 0,0,0,0,0,1,1,1,1,1, each 16 clocks; cmd_sent rises at E0+320.
REQ-031 BAUD_DIV=16, drive RX frame for 8'hA5 -> resp=A5 with one-cycle resp_rdy about 152 clocks after the start edge (plus 2 sync cycles).
REQ-032 Pulse send_cmd again with cmd=16'h4000 at E0+50 during a 16'h2BF0 send -> line carries 2B,F0 only; cmd_sent at E0+320.
REQ-033 Drive RX frame 8'h3C with stop bit 0 -> no resp_rdy and resp unchanged; the next good 8'h5A frame -> resp=5A and resp_rdy pulses.
REQ-034 Assert RST_n=0 at E0+100 of a send and in mid-RX frame -> TX=1 immediately, cmd_sent stays 0, no resp_rdy; a subsequent send of 16'h0000 completes normally.
